// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (AND/OR/XOR/NAND) among NREQ requesters.
// Latency: 2 edges from the sampled request to result_valid (grant edge, then execute edge); one op per 2 cycles.
// Backpressure: a requester holds req/operands until it sees its gnt bit; requests are not sampled while executing.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req[NREQ]            per-requester request
//   req_op[2*NREQ]       opcode of requester i at [2i+1:2i] (00 AND, 01 OR, 10 XOR, 11 NAND)
//   req_a/req_b          operands of requester i at [WIDTH*i +: WIDTH]
//   gnt                  one-hot grant pulse
//   busy                 high while executing
//   result/result_id     last result and the requester it belongs to
//   result_valid         one-cycle pulse marking a new result
//   op_count             completed operations, wraps at 16 bits
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [WIDTH-1:0]        result,
    output logic                    result_valid,
    output logic [IDW-1:0]          result_id,
    output logic [15:0]             op_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   wid_q, wid_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [IDW-1:0]   result_id_q, result_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] alu_out;

    // Scan requesters starting at ptr and wrapping; the first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Operates only on the operands captured at grant time.
    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_AND:  alu_out = a_q & b_q;
            OP_OR:   alu_out = a_q | b_q;
            OP_XOR:  alu_out = a_q ^ b_q;
            OP_NAND: alu_out = ~(a_q & b_q);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        wid_d          = wid_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        gnt_d          = '0;
        busy_d         = busy_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        op_count_d     = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    wid_d   = win_id;
                    op_d    = req_op[2*win_id +: 2];
                    a_d     = req_a[WIDTH*win_id +: WIDTH];
                    b_d     = req_b[WIDTH*win_id +: WIDTH];
                    gnt_d   = NREQ'(1) << win_id;
                    busy_d  = 1'b1;
                    ptr_d   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d       = alu_out;
                result_valid_d = 1'b1;
                result_id_d    = wid_q;
                op_count_d     = op_count_q + 16'd1;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset wins over EXEC, so an in-flight operation is dropped without a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            wid_q          <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            gnt_q          <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            wid_q          <= wid_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            gnt_q          <= gnt_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            op_count_q     <= op_count_d;
        end
    end

    assign gnt          = gnt_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: table of single-requester operations plus contention, wrap and reset sequences.
// Expected results are queued when a request is driven and checked when result_valid pulses.
// Requesters drop req after seeing their grant.
module tb_logic_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      result;
    logic                  result_valid;
    logic [IDW-1:0]        result_id;
    logic [15:0]           op_count;

    logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .gnt          (gnt),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [7:0]  res;
        logic [15:0] cnt;
    } sb_t;

    sb_t         sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*id +: 2] = op;
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
    endtask

    task automatic push(input int id, input logic [7:0] res);
        sb_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.id  = id;
        e.res = res;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic run_single(input int id, input logic [1:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] exp);
        set_req(id, op, a, b);
        req = 4'b0001 << id;
        push(id, exp);
        tick();
        chk("gnt", 32'(gnt), 32'(1) << id);
        chk("busy_exec", 32'(busy), 32'd1);
        req = '0;
        tick();
        chk("gnt_pulse", 32'(gnt), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        tick();
    endtask

    // Scoreboard: every result_valid pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: result_valid=1 with nothing pending, required 0");
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("result_id", 32'(result_id), e.id);
                chk("op_count", 32'(op_count), 32'(e.cnt));
            end
        end
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 2'b00, 8'hF0, 8'h3C, 8'h30};
        vecs[1] = '{2, 2'b01, 8'hA5, 8'h0F, 8'hAF};
        vecs[2] = '{2, 2'b10, 8'hA5, 8'h0F, 8'hAA};
        vecs[3] = '{2, 2'b11, 8'hA5, 8'h0F, 8'hFA};
        vecs[4] = '{1, 2'b00, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{3, 2'b11, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{3, 2'b01, 8'h00, 8'h00, 8'h00};
        vecs[7] = '{1, 2'b10, 8'h5A, 8'hA5, 8'hFF};

        rst     = 1'b1;
        req     = '0;
        req_op  = '0;
        req_a   = '0;
        req_b   = '0;
        exp_cnt = '0;

        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_id", 32'(result_id), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++)
            run_single(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);

        // Idle cycles must leave the last result untouched.
        tick();
        tick();
        chk("hold_result", 32'(result), 32'hFF);
        chk("hold_id", 32'(result_id), 32'd1);
        chk("hold_valid", 32'(result_valid), 32'd0);
        chk("hold_gnt", 32'(gnt), 32'd0);

        // Operands changed while gnt is high must not reach the result.
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        req = 4'b0001;
        push(0, 8'h30);
        tick();
        chk("late_gnt", 32'(gnt), 32'h1);
        set_req(0, 2'b01, 8'h0F, 8'h0F);
        req = '0;
        tick();
        tick();

        // Reset during EXEC drops the operation.
        set_req(1, 2'b10, 8'hFF, 8'h00);
        req = 4'b0010;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        req = '0;
        tick();
        chk("mid_valid", 32'(result_valid), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_count", 32'(op_count), 32'd0);
        chk("mid_gnt_clr", 32'(gnt), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        rst     = 1'b0;
        exp_cnt = '0;
        tick();
        run_single(2, 2'b10, 8'h3C, 8'h0F, 8'h33);
        run_single(3, 2'b01, 8'h12, 8'h34, 8'h36);

        // All four request together; pointer is at 0 after requester 3 was served.
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        set_req(1, 2'b01, 8'h0F, 8'hF0);
        set_req(2, 2'b10, 8'hFF, 8'h0F);
        set_req(3, 2'b11, 8'h0F, 8'h0F);
        req = 4'b1111;
        push(0, 8'h30);
        push(1, 8'hFF);
        push(2, 8'hF0);
        push(3, 8'hF0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_gnt", 32'(gnt), 32'(1) << i);
            chk("cont_busy", 32'(busy), 32'd1);
            req[i] = 1'b0;
            tick();
            chk("cont_gnt_pulse", 32'(gnt), 32'd0);
        end
        tick();

        // Wrap: with ptr back at 0, requester 1 precedes requester 3.
        set_req(1, 2'b00, 8'hAA, 8'h0F);
        set_req(3, 2'b11, 8'hF0, 8'hFF);
        req = 4'b1010;
        push(1, 8'h0A);
        push(3, 8'h0F);
        tick();
        chk("wrap_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick();
        tick();
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        tick();
        tick();

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
